mul12u_dot_acc: RTL

- Downstream consumer of the 12x12 unsigned approximate multiplier family (24-bit product output).
- Accumulates a stream of products into a dot-product sum, one group at a time, and presents each finished sum on a valid/ready output.
- A group closes after LEN products or when in_last is asserted.
- Used to evaluate approximate multipliers inside MAC / filter datapaths on FPGA.

---
 rtl/mul12u_dot_acc.sv | 111 +++++++++++
 1 files changed

// File: rtl/mul12u_dot_acc.sv
// Dot-product accumulator for a stream of unsigned multiplier products.
// Each group closes after LEN beats or on in_last, and its sum is held on a valid/ready output.
//
// state | meaning
// ACCUM | accepting products into acc; in_ready=1, out_valid=0
// HOLD  | finished group presented downstream; in_ready=0, out_valid=1
module mul12u_dot_acc #(
  parameter int PROD_W = 24,
  parameter int ACC_W  = 32,
  parameter int LEN    = 8,
  parameter int SAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [7:0]        out_count,
  output logic              out_ovf
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [7:0] LEN_C = 8'(LEN);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic [7:0]       out_count_q, out_count_d;
  logic             out_ovf_q, out_ovf_d;

  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_n;
  logic [7:0]       cnt_n;
  logic             ovf_n;

  always_comb begin
    sum   = {1'b0, acc_q} + (ACC_W+1)'(in_prod);
    cnt_n = cnt_q + 8'd1;
    ovf_n = ovf_q | sum[ACC_W];
    if (sum[ACC_W] && (SAT != 0)) acc_n = '1;
    else                          acc_n = sum[ACC_W-1:0];
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    case (state_q)
      ACCUM: begin
        if (in_valid) begin
          if (cnt_n == LEN_C || in_last) begin
            out_sum_d   = acc_n;
            out_count_d = cnt_n;
            out_ovf_d   = ovf_n;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            state_d     = HOLD;
          end else begin
            acc_d = acc_n;
            cnt_d = cnt_n;
            ovf_d = ovf_n;
          end
        end
      end
      HOLD: begin
        // Result registers keep their contents after release; only valid drops.
        if (out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

endmodule
